// File: rtl/rv_pipe_pkg.sv
`default_nettype none
// ============================================================================
// rv_pipe_pkg: shared RV32I pipeline types, opcodes and scoreboard helpers.
// Revision: 1.0
// ============================================================================
package rv_pipe_pkg;

    // Register fields in an RV32I instruction are always 5 bits wide.
    localparam int REG_AW = 5;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] LUI    = 7'b0110111;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] addr;
    } sb_entry_t;

    // One-hot register select; indices outside the register file give zero.
    function automatic logic [31:0] onehot_reg(input logic [REG_AW-1:0] addr,
                                               input int                num_regs);
        logic [31:0] mask;
        mask = '0;
        if (int'(addr) < num_regs) begin
            mask[addr] = 1'b1;
        end
        return mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rv_reg_use_decoder.sv
`default_nettype none
// ============================================================================
// rv_reg_use_decoder: combinational decode of destination write and source use.
// Revision: 1.0
// ============================================================================
module rv_reg_use_decoder
    import rv_pipe_pkg::*;
#(
    parameter int NUM_REGS = 32
) (
    input  logic [31:0]       instr,
    output logic              rd_we,
    output logic [REG_AW-1:0] rd,
    output logic              rs1_used,
    output logic [REG_AW-1:0] rs1,
    output logic              rs2_used,
    output logic [REG_AW-1:0] rs2
);

    logic [6:0] opcode;
    logic       writes;
    logic       reads_rs1;
    logic       reads_rs2;
    logic       unused_fields;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];

    assign unused_fields = ^{instr[31:25], instr[14:12]};

    always_comb begin
        writes    = 1'b0;
        reads_rs1 = 1'b0;
        reads_rs2 = 1'b0;
        case (opcode)
            OP: begin
                writes    = 1'b1;
                reads_rs1 = 1'b1;
                reads_rs2 = 1'b1;
            end
            OP_IMM, LOAD, JALR: begin
                writes    = 1'b1;
                reads_rs1 = 1'b1;
            end
            JAL, AUIPC, LUI: begin
                writes    = 1'b1;
            end
            STORE, BRANCH: begin
                reads_rs1 = 1'b1;
                reads_rs2 = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // x0 and out-of-range registers neither create nor see hazards.
    assign rd_we    = writes    && (rd  != '0) && (int'(rd)  < NUM_REGS);
    assign rs1_used = reads_rs1 && (rs1 != '0) && (int'(rs1) < NUM_REGS);
    assign rs2_used = reads_rs2 && (rs2 != '0) && (int'(rs2) < NUM_REGS);

endmodule
`default_nettype wire

// File: rtl/reg_write_scoreboard.sv
`default_nettype none
// ============================================================================
// reg_write_scoreboard: tracks in-flight register writes from issue to
// writeback and stalls issue on RAW hazards against them.
// Revision: 1.0
// ============================================================================
module reg_write_scoreboard
    import rv_pipe_pkg::*;
#(
    parameter int NUM_REGS    = 32,
    parameter int DEPTH       = 3,
    parameter int FLUSH_DEPTH = 2,
    parameter int WB_BYPASS   = 1,
    parameter int AW          = $clog2(NUM_REGS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       issue_valid,
    input  logic [31:0]                issue_instr,
    input  logic                       advance,
    input  logic                       flush,
    output logic                       issue_stall,
    output logic                       issue_accept,
    output logic [NUM_REGS-1:0]        pending_mask,
    output logic                       wb_valid,
    output logic [AW-1:0]              wb_addr,
    output logic [$clog2(DEPTH+1)-1:0] in_flight
);

    localparam int CW = $clog2(DEPTH + 1);

    sb_entry_t         stage_q [DEPTH];
    sb_entry_t         stage_d [DEPTH];
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     count_d;
    logic [31:0]       pend_all;

    logic              rd_we;
    logic [REG_AW-1:0] rd;
    logic              rs1_used;
    logic [REG_AW-1:0] rs1;
    logic              rs2_used;
    logic [REG_AW-1:0] rs2;
    logic              rs1_hit;
    logic              rs2_hit;

    rv_reg_use_decoder #(
        .NUM_REGS (NUM_REGS)
    ) u_decoder (
        .instr    (issue_instr),
        .rd_we    (rd_we),
        .rd       (rd),
        .rs1_used (rs1_used),
        .rs1      (rs1),
        .rs2_used (rs2_used),
        .rs2      (rs2)
    );

    // The writeback stage only counts when the register file cannot forward it.
    always_comb begin
        pend_all = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (stage_q[i].valid && ((i < DEPTH - 1) || (WB_BYPASS == 0))) begin
                pend_all |= onehot_reg(stage_q[i].addr, NUM_REGS);
            end
        end
    end

    assign pending_mask = pend_all[NUM_REGS-1:0];

    assign rs1_hit      = rs1_used && (|(onehot_reg(rs1, NUM_REGS) & pend_all));
    assign rs2_hit      = rs2_used && (|(onehot_reg(rs2, NUM_REGS) & pend_all));
    assign issue_stall  = issue_valid && (rs1_hit || rs2_hit);
    assign issue_accept = issue_valid && !issue_stall && advance && !flush;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i];
        end
        if (advance) begin
            for (int i = DEPTH - 1; i >= 1; i--) begin
                stage_d[i] = stage_q[i-1];
            end
            stage_d[0].valid = issue_accept && rd_we;
            stage_d[0].addr  = rd;
        end
        // Squash applies after the shift so the youngest positions end up empty.
        if (flush) begin
            for (int i = 0; i < FLUSH_DEPTH; i++) begin
                stage_d[i].valid = 1'b0;
            end
        end
        count_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count_d = count_d + CW'(stage_d[i].valid);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
            count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
            count_q <= count_d;
        end
    end

    assign wb_valid  = stage_q[DEPTH-1].valid;
    assign wb_addr   = stage_q[DEPTH-1].addr[AW-1:0];
    assign in_flight = count_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_write_scoreboard.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_reg_write_scoreboard: directed and random checks of two scoreboard
// configurations against a slot-list reference model.
// Revision: 1.0
// ============================================================================
module tb_reg_write_scoreboard;

    localparam int DEPTH       = 3;
    localparam int FLUSH_DEPTH = 2;

    localparam logic [6:0] T_OP     = 7'b0110011;
    localparam logic [6:0] T_OP_IMM = 7'b0010011;
    localparam logic [6:0] T_LOAD   = 7'b0000011;
    localparam logic [6:0] T_STORE  = 7'b0100011;
    localparam logic [6:0] T_BRANCH = 7'b1100011;
    localparam logic [6:0] T_JAL    = 7'b1101111;
    localparam logic [6:0] T_JALR   = 7'b1100111;
    localparam logic [6:0] T_AUIPC  = 7'b0010111;
    localparam logic [6:0] T_LUI    = 7'b0110111;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        issue_valid = 1'b0;
    logic [31:0] issue_instr = '0;
    logic        advance = 1'b0;
    logic        flush = 1'b0;

    logic        stall0, acc0, wbv0;
    logic [4:0]  wba0;
    logic [1:0]  inf0;
    logic [31:0] pm0;
    logic        stall1, acc1, wbv1;
    logic [3:0]  wba1;
    logic [1:0]  inf1;
    logic [15:0] pm1;

    int vectors = 0;
    int miscompares = 0;

    // Instance 0: 32 registers with writeback bypass; instance 1: RV32E, no bypass.
    int nregs  [2] = '{32, 16};
    int bypass [2] = '{1, 0};
    bit m_val  [2][DEPTH];
    int m_addr [2][DEPTH];

    int s0, s1;
    bit d0, d1;
    logic [6:0] opcs [10] = '{T_OP, T_OP_IMM, T_LOAD, T_STORE, T_BRANCH,
                              T_JAL, T_JALR, T_AUIPC, T_LUI, 7'b1111111};

    always #5 clk = ~clk;

    reg_write_scoreboard u_dut0 (
        .clk          (clk),
        .rst_n        (rst_n),
        .issue_valid  (issue_valid),
        .issue_instr  (issue_instr),
        .advance      (advance),
        .flush        (flush),
        .issue_stall  (stall0),
        .issue_accept (acc0),
        .pending_mask (pm0),
        .wb_valid     (wbv0),
        .wb_addr      (wba0),
        .in_flight    (inf0)
    );

    reg_write_scoreboard #(
        .NUM_REGS  (16),
        .WB_BYPASS (0)
    ) u_dut1 (
        .clk          (clk),
        .rst_n        (rst_n),
        .issue_valid  (issue_valid),
        .issue_instr  (issue_instr),
        .advance      (advance),
        .flush        (flush),
        .issue_stall  (stall1),
        .issue_accept (acc1),
        .pending_mask (pm1),
        .wb_valid     (wbv1),
        .wb_addr      (wba1),
        .in_flight    (inf1)
    );

    function automatic logic [31:0] enc(input logic [6:0] opc, input int rd,
                                        input int rs1, input int rs2);
        return {7'b0, 5'(rs2), 5'(rs1), 3'b0, 5'(rd), opc};
    endfunction

    function automatic void decode(input logic [31:0] ins, input int nr,
                                   output bit we, output int rd,
                                   output bit u1, output int r1,
                                   output bit u2, output int r2);
        bit w, a, b;
        w = 0; a = 0; b = 0;
        rd = int'(ins[11:7]);
        r1 = int'(ins[19:15]);
        r2 = int'(ins[24:20]);
        case (ins[6:0])
            T_OP:                     begin w = 1; a = 1; b = 1; end
            T_OP_IMM, T_LOAD, T_JALR: begin w = 1; a = 1; end
            T_JAL, T_AUIPC, T_LUI:    begin w = 1; end
            T_STORE, T_BRANCH:        begin a = 1; b = 1; end
            default:                  begin end
        endcase
        we = w && rd != 0 && rd < nr;
        u1 = a && r1 != 0 && r1 < nr;
        u2 = b && r2 != 0 && r2 < nr;
    endfunction

    function automatic logic [31:0] m_pend(input int k);
        logic [31:0] p;
        p = '0;
        for (int d = 0; d < DEPTH; d++) begin
            if (m_val[k][d] && (d < DEPTH - 1 || bypass[k] == 0)) p[m_addr[k][d]] = 1'b1;
        end
        return p;
    endfunction

    function automatic int m_count(input int k);
        int c;
        c = 0;
        for (int d = 0; d < DEPTH; d++) c += int'(m_val[k][d]);
        return c;
    endfunction

    function automatic bit exp_stall(input int k);
        bit we, u1, u2;
        int rd, r1, r2;
        logic [31:0] p;
        decode(issue_instr, nregs[k], we, rd, u1, r1, u2, r2);
        p = m_pend(k);
        return issue_valid && ((u1 && p[r1]) || (u2 && p[r2]));
    endfunction

    function automatic bit exp_accept(input int k);
        return issue_valid && !exp_stall(k) && advance && !flush;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 2; k++)
            for (int d = 0; d < DEPTH; d++) begin
                m_val[k][d]  = 0;
                m_addr[k][d] = 0;
            end
    endfunction

    function automatic void model_edge();
        bit a, we, u1, u2;
        int rd, r1, r2;
        for (int k = 0; k < 2; k++) begin
            a = exp_accept(k);
            decode(issue_instr, nregs[k], we, rd, u1, r1, u2, r2);
            if (advance) begin
                for (int d = DEPTH - 1; d >= 1; d--) begin
                    m_val[k][d]  = m_val[k][d-1];
                    m_addr[k][d] = m_addr[k][d-1];
                end
                m_val[k][0]  = a && we;
                m_addr[k][0] = rd % nregs[k];
            end
            if (flush)
                for (int d = 0; d < FLUSH_DEPTH; d++) m_val[k][d] = 0;
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("stall0",  32'(stall0), 32'(exp_stall(0)));
        chk("accept0", 32'(acc0),   32'(exp_accept(0)));
        chk("pend0",   pm0,         m_pend(0));
        chk("wbv0",    32'(wbv0),   32'(m_val[0][DEPTH-1]));
        if (m_val[0][DEPTH-1]) chk("wba0", 32'(wba0), 32'(m_addr[0][DEPTH-1]));
        chk("inflight0", 32'(inf0), 32'(m_count(0)));
        chk("stall1",  32'(stall1), 32'(exp_stall(1)));
        chk("accept1", 32'(acc1),   32'(exp_accept(1)));
        chk("pend1",   {16'h0, pm1}, m_pend(1));
        chk("wbv1",    32'(wbv1),   32'(m_val[1][DEPTH-1]));
        if (m_val[1][DEPTH-1]) chk("wba1", 32'(wba1), 32'(m_addr[1][DEPTH-1]));
        chk("inflight1", 32'(inf1), 32'(m_count(1)));
    endtask

    task automatic step(input bit iv, input logic [31:0] ins, input bit adv, input bit fl);
        issue_valid = iv;
        issue_instr = ins;
        advance     = adv;
        flush       = fl;
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all();
        chk("rst_wba0", 32'(wba0), 32'h0);
        chk("rst_wba1", 32'(wba1), 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        model_edge();
        #1;

        // Independent writers: ADDI x5,x0,1 then ADD x6,x1,x2.
        step(1'b1, enc(T_OP_IMM, 5, 0, 1), 1'b1, 1'b0);
        step(1'b1, enc(T_OP, 6, 1, 2), 1'b1, 1'b0);
        chk("indep_pend0", pm0, 32'h0000_0060);
        chk("indep_inflight0", 32'(inf0), 32'd2);
        idle(1);
        chk("indep_wbv0", 32'(wbv0), 32'd1);
        chk("indep_wba0", 32'(wba0), 32'd5);
        idle(3);

        // RAW: ADDI x5 then ADD x7,x5,x1 retried each cycle.
        step(1'b1, enc(T_OP_IMM, 5, 0, 1), 1'b1, 1'b0);
        s0 = 0; s1 = 0; d0 = 0; d1 = 0;
        for (int i = 0; i < 10 && !(d0 && d1); i++) begin
            issue_valid = 1'b1;
            issue_instr = enc(T_OP, 7, 5, 1);
            advance     = 1'b1;
            flush       = 1'b0;
            @(negedge clk);
            check_all();
            if (!d0) begin if (acc0) d0 = 1; else if (stall0) s0++; end
            if (!d1) begin if (acc1) d1 = 1; else if (stall1) s1++; end
            @(posedge clk);
            model_edge();
            #1;
        end
        chk("raw_accepted0", 32'(d0), 32'd1);
        chk("raw_accepted1", 32'(d1), 32'd1);
        chk("raw_stalls_bypass", 32'(s0), 32'd2);
        chk("raw_stalls_nobypass", 32'(s1), 32'd3);
        idle(3);

        // Non-writers, x0 and an out-of-range rd for the 16-register instance.
        step(1'b1, enc(T_STORE, 0, 1, 5), 1'b1, 1'b0);
        step(1'b1, enc(T_BRANCH, 0, 1, 2), 1'b1, 1'b0);
        step(1'b1, enc(T_OP_IMM, 0, 0, 0), 1'b1, 1'b0);
        step(1'b1, enc(T_LUI, 3, 0, 0), 1'b1, 1'b0);
        step(1'b1, enc(T_LUI, 17, 0, 0), 1'b1, 1'b0);
        chk("nw_pend1", {16'h0, pm1}, 32'h0000_0008);
        chk("nw_pend0", pm0, 32'h0002_0008);
        chk("nw_inflight1", 32'(inf1), 32'd1);
        idle(3);

        // Hold: three writers then advance low for four cycles.
        step(1'b1, enc(T_LUI, 1, 0, 0), 1'b1, 1'b0);
        step(1'b1, enc(T_LUI, 2, 0, 0), 1'b1, 1'b0);
        step(1'b1, enc(T_LUI, 3, 0, 0), 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, enc(T_OP_IMM, 4, 0, 1), 1'b0, 1'b0);
            chk("hold_wbv0", 32'(wbv0), 32'd1);
            chk("hold_wba0", 32'(wba0), 32'd1);
            chk("hold_inflight0", 32'(inf0), 32'd3);
            chk("hold_accept0", 32'(acc0), 32'd0);
        end
        idle(3);

        // Flush with advance: x1 youngest, x3 oldest.
        step(1'b1, enc(T_LUI, 3, 0, 0), 1'b1, 1'b0);
        step(1'b1, enc(T_LUI, 2, 0, 0), 1'b1, 1'b0);
        step(1'b1, enc(T_LUI, 1, 0, 0), 1'b1, 1'b0);
        step(1'b1, enc(T_OP_IMM, 9, 0, 1), 1'b1, 1'b1);
        chk("flush_wbv1", 32'(wbv1), 32'd1);
        chk("flush_wba1", 32'(wba1), 32'd2);
        chk("flush_pend1", {16'h0, pm1}, 32'h0000_0004);
        chk("flush_pend0", pm0, 32'h0);
        chk("flush_inflight0", 32'(inf0), 32'd1);
        idle(3);

        // Asynchronous reset between edges with a full tracker.
        step(1'b1, enc(T_LUI, 1, 0, 0), 1'b1, 1'b0);
        step(1'b1, enc(T_LUI, 2, 0, 0), 1'b1, 1'b0);
        step(1'b1, enc(T_LUI, 3, 0, 0), 1'b1, 1'b0);
        issue_valid = 1'b0;
        advance     = 1'b1;
        flush       = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        chk("areset_pend0", pm0, 32'h0);
        chk("areset_wbv0", 32'(wbv0), 32'd0);
        chk("areset_inflight0", 32'(inf0), 32'd0);
        chk("areset_pend1", {16'h0, pm1}, 32'h0);
        chk("areset_wbv1", 32'(wbv1), 32'd0);
        chk("areset_inflight1", 32'(inf1), 32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        model_edge();
        #1;
        for (int i = 0; i < 3; i++) begin
            idle(1);
            chk("areset_no_wb0", 32'(wbv0), 32'd0);
            chk("areset_no_wb1", 32'(wbv1), 32'd0);
        end

        // Random traffic biased towards a few registers to provoke hazards.
        for (int n = 0; n < 400; n++) begin
            int rd, r1, r2;
            rd = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
            r1 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
            r2 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
            step(($urandom_range(0, 3) != 0),
                 enc(opcs[$urandom_range(0, 9)], rd, r1, r2),
                 ($urandom_range(0, 4) != 0),
                 ($urandom_range(0, 9) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_write_scoreboard.md
Name: reg_write_scoreboard

Overview:
- Tracks in-flight register writes between issue and writeback for the RV32I pipeline.
- Decodes each issued instruction's destination and source usage, and stalls issue on RAW hazards against pending writes.
- Shifts write entries down a DEPTH-stage tracker and presents the retiring write at writeback.
- Squashes younger entries on a branch-mispredict flush. Sits between decode/issue and the register file.

Parameters:
- NUM_REGS, 32, architectural register count (16 gives RV32E; rd/rs indices at or above NUM_REGS are ignored).
- DEPTH, 3, tracker stages from issue (stage 0) to writeback (stage DEPTH-1); minimum 2.
- FLUSH_DEPTH, 2, number of youngest stages (0..FLUSH_DEPTH-1) invalidated by flush; must be 1 to DEPTH.
- WB_BYPASS, 1, 1 = an entry in stage DEPTH-1 does not count as pending (register file is write-before-read).
- AW, $clog2(NUM_REGS), register address width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- issue_valid  in  1  issue_instr holds a valid instruction.
- issue_instr  in  32  instruction at issue.
- advance  in  1  pipeline moves this cycle; low means hold.
- flush  in  1  mispredict squash.
- issue_stall  out  1  RAW hazard; instruction must not issue.
- issue_accept  out  1  instruction entered stage 0 at this edge.
- pending_mask  out  NUM_REGS  bit r set when a write to r is pending.
- wb_valid  out  1  stage DEPTH-1 holds a valid write.
- wb_addr  out  AW  destination of stage DEPTH-1.
- in_flight  out  $clog2(DEPTH+1)  count of valid stages.

Behaviour:
- Decode (combinational):
  - Writes rd when opcode is OP 0110011, OP-IMM 0010011, LOAD 0000011, JAL 1101111, JALR 1100111, AUIPC 0010111 or LUI 0110111, and rd != 0, and rd < NUM_REGS.
  - STORE, BRANCH and unknown opcodes never write.
  - rs1 is used by OP, OP-IMM, LOAD, STORE, BRANCH and JALR.
  - rs2 is used by OP, STORE and BRANCH.
  - x0 is never a hazard.
- pending_mask (combinational from flops): OR of one-hot(addr) over valid stages 0..DEPTH-2. Stage DEPTH-1 is included only if WB_BYPASS=0. Multiple writes to the same register collapse into one bit.
- issue_stall = issue_valid and ((rs1 used and pending[rs1]) or (rs2 used and pending[rs2])). It is independent of advance and flush.
- issue_accept = issue_valid and !issue_stall and advance and !flush.
- Stage entry: {valid, addr}.
  - When advance=1, on the clock edge: stage[i] <= stage[i-1] for i >= 1. stage[0] <= {issue_accept and decoded write, rd}. A non-writing instruction inserts a bubble (valid=0).
  - When advance=0, all stages hold.
- Flush: the next-state stages are computed as above, then stages 0..FLUSH_DEPTH-1 are forced valid=0 at that edge. This applies with or without advance. Stages at or above FLUSH_DEPTH are unaffected.
- wb_valid/wb_addr are driven directly from stage DEPTH-1. The write retires when advance moves it out. With advance low, the same write is presented every cycle; the register file must use the wb_valid and advance qualifier.
- in_flight = popcount of stage valid bits, registered alongside the stages and updated every edge.
- Reset (asynchronous, rst_n low): all stage valid=0, addr=0.
  - This makes pending_mask=0, wb_valid=0, wb_addr=0, in_flight=0, issue_stall=0 and issue_accept=0 (with issue_valid low).
  - Reset mid-operation discards all in-flight entries without a retire.
- Latency: an accepted writer is pending the cycle after issue. It reaches writeback DEPTH-1 advance-edges later.
- Boundaries:
  - Back-to-back writes to the same rd stay pending until the youngest leaves.
  - A dependent instruction re-evaluates every cycle and issues the cycle its producer's entry stops counting.

Decomposition:
- Package rv_pipe_pkg holds:
  - opcode localparams (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, AUIPC, LUI);
  - typedef sb_entry_t {logic valid; logic [AW-1:0] addr};
  - function onehot_reg(addr, NUM_REGS).
- One combinational sub-module, rv_reg_use_decoder: instr in; rd_we, rd, rs1_used, rs1, rs2_used, rs2 out. NUM_REGS is a parameter.

Test Plan:
- Reset and independent issue: reset, issue ADDI x5,x0,1 then ADD x6,x1,x2 with advance=1 each cycle -> no stall. pending_mask bits 5 and 6 set. wb_valid with wb_addr=5 after 2 more edges (DEPTH=3). in_flight peaks at 2.
- RAW stall: ADDI x5 followed by ADD x7,x5,x1 -> issue_stall=1 for 2 cycles with WB_BYPASS=1, then accept. Rerun with WB_BYPASS=0 -> 3 stall cycles.
- Non-writers and x0: SW x5,0(x1); BEQ x1,x2; ADDI x0,x0,0; LUI x3 with NUM_REGS=16 and rd=17 -> no stage 0 valid except LUI x3 (rd=3). pending_mask shows only bit 3.
- Hold: fill 3 writers x1,x2,x3 and drop advance for 4 cycles -> stages hold. wb_addr=1 and wb_valid=1 are stable, in_flight=3, and a valid issue gets issue_accept=0.
- Flush: stages hold x1(0), x2(1), x3(2); assert flush with advance=1 and FLUSH_DEPTH=2 -> next stage 2 = x2 only. pending_mask = bit 2 only (WB_BYPASS=0). The issuing instruction is not accepted.
- Async reset mid-operation: pulse rst_n low between edges with 3 valid entries -> pending_mask, wb_valid and in_flight go to 0 immediately, with no wb pulse after release.
